// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and pipe_hazard_ctrl.
// The master drives the hazard inputs; the slave (controller) drives enables, state and counters.
interface pipe_hazard_ctrl_if #(
    parameter int STALL_CNT_W = 16,
    parameter int FLUSH_CNT_W = 8
);
    logic [2:0]             id_rs;
    logic [2:0]             id_rt;
    logic                   id_rs_used;
    logic                   id_rt_used;
    logic                   idex_Mem_read;
    logic [2:0]             idex_write_sel;
    logic                   branch_taken;
    logic                   mem_busy;
    logic                   halt_req;
    logic                   pc_en;
    logic                   ifid_en;
    logic                   idex_en;
    logic                   exmem_en;
    logic                   ifid_flush;
    logic                   idex_bubble;
    logic [2:0]             state_o;
    logic [STALL_CNT_W-1:0] stall_cnt;
    logic [FLUSH_CNT_W-1:0] flush_cnt;

    modport master (
        output id_rs, id_rt, id_rs_used, id_rt_used, idex_Mem_read, idex_write_sel,
               branch_taken, mem_busy, halt_req,
        input  pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_bubble,
               state_o, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs, id_rt, id_rs_used, id_rt_used, idex_Mem_read, idex_write_sel,
               branch_taken, mem_busy, halt_req,
        output pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_bubble,
               state_o, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Five-stage pipeline sequencing controller: load-use stalls, branch flushes,
// memory-wait freezes and halt, with saturating stall/flush event counters.
module pipe_hazard_ctrl #(
    parameter int STALL_CNT_W = 16,
    parameter int FLUSH_CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    pipe_hazard_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_RUN     = 3'd0,
        ST_LDUSE   = 3'd1,
        ST_MEMWAIT = 3'd2,
        ST_HALTED  = 3'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [STALL_CNT_W-1:0] r_stall_cnt;
    logic [FLUSH_CNT_W-1:0] r_flush_cnt;

    logic w_lu;
    logic w_lu_act;
    logic w_legal;
    logic w_pc_en;
    logic w_ifid_en;
    logic w_idex_en;
    logic w_exmem_en;
    logic w_ifid_flush;
    logic w_idex_bubble;
    logic w_flush_inc;

    function automatic logic [STALL_CNT_W-1:0] sat_inc_stall(input logic [STALL_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [FLUSH_CNT_W-1:0] sat_inc_flush(input logic [FLUSH_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign w_lu = bus.idex_Mem_read &
                  ((bus.id_rs_used & (bus.id_rs == bus.idex_write_sel)) |
                   (bus.id_rt_used & (bus.id_rt == bus.idex_write_sel)));

    assign w_legal  = (r_state == ST_RUN) || (r_state == ST_LDUSE) ||
                      (r_state == ST_MEMWAIT) || (r_state == ST_HALTED);
    // The stalled consumer already waited one cycle in LDUSE; a re-check would double-stall.
    assign w_lu_act = w_lu && (r_state != ST_LDUSE) && (r_state != ST_MEMWAIT);

    always_comb begin
        w_pc_en       = 1'b1;
        w_ifid_en     = 1'b1;
        w_idex_en     = 1'b1;
        w_exmem_en    = 1'b1;
        w_ifid_flush  = 1'b0;
        w_idex_bubble = 1'b0;
        w_flush_inc   = 1'b0;
        w_state_nxt   = ST_RUN;
        if (rst) begin
            {w_pc_en, w_ifid_en, w_idex_en, w_exmem_en} = 4'b0000;
            w_ifid_flush  = 1'b1;
            w_idex_bubble = 1'b1;
        end else if (r_state == ST_HALTED) begin
            {w_pc_en, w_ifid_en, w_idex_en, w_exmem_en} = 4'b0000;
            w_state_nxt = ST_HALTED;
        end else begin
            if (bus.halt_req) begin
                {w_pc_en, w_ifid_en, w_idex_en, w_exmem_en} = 4'b0000;
                w_state_nxt = ST_HALTED;
            end else if (bus.mem_busy) begin
                {w_pc_en, w_ifid_en, w_idex_en, w_exmem_en} = 4'b0000;
                w_state_nxt = ST_MEMWAIT;
            end else if (bus.branch_taken) begin
                w_ifid_flush  = 1'b1;
                w_idex_bubble = 1'b1;
                w_flush_inc   = 1'b1;
            end else if (w_lu_act) begin
                w_pc_en       = 1'b0;
                w_ifid_en     = 1'b0;
                w_idex_bubble = 1'b1;
                w_state_nxt   = ST_LDUSE;
            end
            if (!w_legal) begin
                w_state_nxt = ST_RUN;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (!w_pc_en) begin
                r_stall_cnt <= sat_inc_stall(r_stall_cnt);
            end
            if (w_flush_inc) begin
                r_flush_cnt <= sat_inc_flush(r_flush_cnt);
            end
        end
    end

    assign bus.pc_en       = w_pc_en;
    assign bus.ifid_en     = w_ifid_en;
    assign bus.idex_en     = w_idex_en;
    assign bus.exmem_en    = w_exmem_en;
    assign bus.ifid_flush  = w_ifid_flush;
    assign bus.idex_bubble = w_idex_bubble;
    assign bus.state_o     = r_state;
    assign bus.stall_cnt   = r_stall_cnt;
    assign bus.flush_cnt   = r_flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: reset, load-use, branch, memory wait,
// flush-counter saturation and halt, checked with immediate assertions.
module tb_pipe_hazard_ctrl;

    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;

    pipe_hazard_ctrl_if #(.STALL_CNT_W(16), .FLUSH_CNT_W(8)) bus ();

    pipe_hazard_ctrl #(.STALL_CNT_W(16), .FLUSH_CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_bubble}
    logic [5:0] ctl;
    assign ctl = {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.ifid_flush, bus.idex_bubble};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.id_rs          = 3'd0;
        bus.id_rt          = 3'd0;
        bus.id_rs_used     = 1'b0;
        bus.id_rt_used     = 1'b0;
        bus.idex_Mem_read  = 1'b0;
        bus.idex_write_sel = 3'd0;
        bus.branch_taken   = 1'b0;
        bus.mem_busy       = 1'b0;
        bus.halt_req       = 1'b0;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        clear_inputs();
        rst = 1'b1;
        #3;
        chk("rst_ctl",   ctl,           6'b000011);
        chk("rst_state", bus.state_o,   3'd0);
        chk("rst_stall", bus.stall_cnt, 16'd0);
        chk("rst_flush", bus.flush_cnt, 8'd0);

        step();
        rst = 1'b0;
        #1;
        chk("run_ctl", ctl, 6'b111100);

        // Load-use on rt
        bus.idex_Mem_read  = 1'b1;
        bus.idex_write_sel = 3'd3;
        bus.id_rt          = 3'd3;
        bus.id_rt_used     = 1'b1;
        #1;
        chk("lu_c0_ctl", ctl, 6'b001101);
        step();
        chk("lu_c1_state", bus.state_o,   3'd1);
        chk("lu_c1_stall", bus.stall_cnt, 16'd1);
        chk("lu_c1_ctl",   ctl,           6'b111100);

        // Asynchronous reset while in LDUSE
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_state", bus.state_o,   3'd0);
        chk("mid_rst_stall", bus.stall_cnt, 16'd0);
        chk("mid_rst_ctl",   ctl,           6'b000011);
        step();
        rst = 1'b0;
        clear_inputs();
        #1;
        chk("post_rst_ctl", ctl, 6'b111100);

        // Matching numbers but rt not read: no stall
        bus.idex_Mem_read  = 1'b1;
        bus.idex_write_sel = 3'd3;
        bus.id_rt          = 3'd3;
        bus.id_rt_used     = 1'b0;
        bus.id_rs          = 3'd5;
        bus.id_rs_used     = 1'b1;
        #1;
        chk("nolu_ctl", ctl, 6'b111100);
        step();
        chk("nolu_state", bus.state_o,   3'd0);
        chk("nolu_stall", bus.stall_cnt, 16'd0);

        // Branch wins over load-use
        bus.id_rt_used   = 1'b1;
        bus.branch_taken = 1'b1;
        #1;
        chk("br_lu_ctl", ctl, 6'b111111);
        step();
        chk("br_lu_state", bus.state_o,   3'd0);
        chk("br_lu_flush", bus.flush_cnt, 8'd1);
        chk("br_lu_stall", bus.stall_cnt, 16'd0);
        clear_inputs();

        // Memory wait for three cycles, then a branch on release
        bus.mem_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("mw_ctl_%0d", i), ctl, 6'b000000);
            step();
            chk($sformatf("mw_state_%0d", i), bus.state_o, 3'd2);
        end
        chk("mw_stall", bus.stall_cnt, 16'd3);
        bus.mem_busy     = 1'b0;
        bus.branch_taken = 1'b1;
        #1;
        chk("mw_rel_ctl", ctl, 6'b111111);
        step();
        chk("mw_rel_state", bus.state_o,   3'd0);
        chk("mw_rel_flush", bus.flush_cnt, 8'd2);
        chk("mw_rel_stall", bus.stall_cnt, 16'd3);

        // Drive flush counter up to saturation
        repeat (253) step();
        chk("flush_full", bus.flush_cnt, 8'd255);
        step();
        chk("flush_sat",     bus.flush_cnt, 8'd255);
        chk("flush_sat_ctl", ctl,           6'b111111);
        clear_inputs();

        // Fresh counters, then halt and hammer the inputs
        #1;
        rst = 1'b1;
        #1;
        rst = 1'b0;
        chk("pre_halt_flush", bus.flush_cnt, 8'd0);
        bus.halt_req = 1'b1;
        #1;
        chk("halt_c0_ctl", ctl, 6'b000000);
        step();
        chk("halt_state", bus.state_o,   3'd3);
        chk("halt_stall", bus.stall_cnt, 16'd1);
        for (int i = 0; i < 10; i++) begin
            bus.halt_req       = i[0];
            bus.mem_busy       = ~i[0];
            bus.branch_taken   = 1'b1;
            bus.idex_Mem_read  = i[1];
            bus.idex_write_sel = i[2:0];
            bus.id_rs          = i[2:0];
            bus.id_rt          = ~i[2:0];
            bus.id_rs_used     = 1'b1;
            bus.id_rt_used     = i[0];
            #1;
            chk($sformatf("halted_ctl_%0d", i), ctl, 6'b000000);
            step();
        end
        chk("halted_state", bus.state_o,   3'd3);
        chk("halted_stall", bus.stall_cnt, 16'd11);
        chk("halted_flush", bus.flush_cnt, 8'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
